ay8_decode_stage: RTL and testbench

- Downstream neighbour of the fetch stage in the AY8 core.
- Consumes the instruction bytes fetch produces (opcode plus optional operand byte, each tagged with its PC) over a valid/ready handshake.
- Assembles 1- or 2-byte instructions and presents one decoded instruction at a time to execute over a second valid/ready handshake.
- Supports a synchronous flush for taken branches and reports reserved opcodes.

---
 rtl/ay8_decode_stage.sv | 108 ++++++++++
 tb/tb_ay8_decode_stage.sv | 176 +++++++++++++++++
 2 files changed

// File: rtl/ay8_decode_stage.sv
// ay8_decode_stage: assembles 1/2-byte AY8 instructions from fetch and hands them to execute.
// Optional instruction counter on out_icount when AY8_DECODE_ICOUNT_EN is defined.
module ay8_decode_stage #(
  parameter int          PC_W     = 8,
  parameter logic [7:0]  IMM_FILL = 8'h00
) (
  input  logic            CLK,
  input  logic            RST,
  input  logic            in_valid,
  output logic            in_ready,
  input  logic [7:0]      in_data,
  input  logic [PC_W-1:0] in_pc,
  input  logic            flush,
  output logic            out_valid,
  input  logic            out_ready,
  output logic [1:0]      out_class,
  output logic [2:0]      out_func,
  output logic [2:0]      out_reg,
  output logic [7:0]      out_imm,
  output logic            out_len,
  output logic [PC_W-1:0] out_pc,
  output logic            out_illegal
`ifdef AY8_DECODE_ICOUNT_EN
  ,
  output logic [15:0]     out_icount
`endif
);
  typedef enum logic [1:0] {OPC, IMM, HOLD} state_t;
  state_t          state_q, state_d;
  logic [1:0]      cls_q, cls_d;
  logic [2:0]      func_q, func_d, reg_q, reg_d;
  logic [7:0]      imm_q, imm_d;
  logic            len_q, len_d, ill_q, ill_d;
  logic [PC_W-1:0] pc_q, pc_d;
  logic            xfer, issue, illegal, len2;
  assign in_ready = !RST && !flush && (state_q != HOLD || out_ready);
  assign xfer     = in_valid && in_ready;
  assign issue    = state_q == HOLD && out_ready && !flush;
  assign illegal  = in_data == 8'hFF;
  assign len2     = !illegal && (in_data[7:6] == 2'b01 || in_data[7:6] == 2'b10 ||
                                 (in_data[7:6] == 2'b11 && in_data[5]));
  always_comb begin
    state_d = state_q;
    cls_d   = cls_q;
    func_d  = func_q;
    reg_d   = reg_q;
    imm_d   = imm_q;
    len_d   = len_q;
    pc_d    = pc_q;
    ill_d   = ill_q;
    unique case (state_q)
      OPC:     state_d = xfer ? (len2 ? IMM : HOLD) : OPC;
      IMM:     state_d = xfer ? HOLD : IMM;
      HOLD:    state_d = issue ? (xfer ? (len2 ? IMM : HOLD) : OPC) : HOLD;
      default: state_d = OPC;
    endcase
    // An opcode may only land when the held instruction is gone, so outputs stay stable in HOLD
    if (xfer && state_q != IMM) begin
      cls_d  = in_data[7:6];
      func_d = in_data[5:3];
      reg_d  = in_data[2:0];
      imm_d  = IMM_FILL;
      len_d  = len2;
      pc_d   = in_pc;
      ill_d  = illegal;
    end
    if (xfer && state_q == IMM) imm_d = in_data;
    if (flush) state_d = OPC;
  end
  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      state_q <= OPC;
      cls_q   <= '0;
      func_q  <= '0;
      reg_q   <= '0;
      imm_q   <= IMM_FILL;
      len_q   <= 1'b0;
      pc_q    <= '0;
      ill_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      cls_q   <= cls_d;
      func_q  <= func_d;
      reg_q   <= reg_d;
      imm_q   <= imm_d;
      len_q   <= len_d;
      pc_q    <= pc_d;
      ill_q   <= ill_d;
    end
  end
  assign out_valid   = state_q == HOLD;
  assign out_class   = cls_q;
  assign out_func    = func_q;
  assign out_reg     = reg_q;
  assign out_imm     = imm_q;
  assign out_len     = len_q;
  assign out_pc      = pc_q;
  assign out_illegal = ill_q;
`ifdef AY8_DECODE_ICOUNT_EN
  logic [15:0] icount_q, icount_d;
  assign icount_d = issue ? icount_q + 16'd1 : icount_q;
  always_ff @(posedge CLK or posedge RST) begin
    if (RST) icount_q <= '0;
    else icount_q <= icount_d;
  end
  assign out_icount = icount_q;
`endif
endmodule

// File: tb/tb_ay8_decode_stage.sv
// tb_ay8_decode_stage: directed self-checking bench for ay8_decode_stage.
module tb_ay8_decode_stage;
  logic       CLK = 1'b0, RST = 1'b1;
  logic       in_valid = 1'b0, in_ready, flush = 1'b0, out_valid, out_ready = 1'b1;
  logic [7:0] in_data = 8'h00, in_pc = 8'h00, out_imm, out_pc;
  logic [1:0] out_class;
  logic [2:0] out_func, out_reg;
  logic       out_len, out_illegal;
  int         errors = 0, checks = 0;
`ifdef AY8_DECODE_ICOUNT_EN
  logic [15:0] out_icount;
`endif
  ay8_decode_stage dut (
    .CLK(CLK), .RST(RST), .in_valid(in_valid), .in_ready(in_ready), .in_data(in_data),
    .in_pc(in_pc), .flush(flush), .out_valid(out_valid), .out_ready(out_ready),
    .out_class(out_class), .out_func(out_func), .out_reg(out_reg), .out_imm(out_imm),
    .out_len(out_len), .out_pc(out_pc), .out_illegal(out_illegal)
`ifdef AY8_DECODE_ICOUNT_EN
    , .out_icount(out_icount)
`endif
  );
  always #5 CLK = ~CLK;
  wire [26:0] snap = {out_valid, out_class, out_func, out_reg, out_imm, out_len, out_pc, out_illegal};
  task automatic tick;
    @(posedge CLK);
    #1;
  endtask
  task automatic send(input logic [7:0] d, input logic [7:0] pc);
    in_valid = 1'b1;
    in_data  = d;
    in_pc    = pc;
  endtask
  task automatic test_reset;
    #3;
    checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL rst_valid got=%0h exp=0", out_valid); end
    checks++; if (in_ready !== 1'b0) begin errors++; $display("FAIL rst_in_ready got=%0h exp=0", in_ready); end
    checks++; if (snap !== 27'd0) begin errors++; $display("FAIL rst_outputs got=%h exp=%h", snap, 27'd0); end
    tick;
    RST = 1'b0;
    #1;
    checks++; if (in_ready !== 1'b1) begin errors++; $display("FAIL rst_release_ready got=%0h exp=1", in_ready); end
  endtask
  task automatic test_one_byte;
    send(8'h0A, 8'h10);
    tick;
    in_valid = 1'b0;
    checks++; if (snap !== {1'b1, 2'd0, 3'd1, 3'd2, 8'h00, 1'b0, 8'h10, 1'b0}) begin errors++; $display("FAIL one_byte got=%h", snap); end
    tick;
    checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL one_byte_drop got=%0h exp=0", out_valid); end
  endtask
  task automatic test_two_byte;
    send(8'h4B, 8'h20);
    tick;
    in_valid = 1'b0;
    for (int i = 0; i < 4; i++) begin
      checks++; if (out_valid !== 1'b0 || in_ready !== 1'b1) begin errors++; $display("FAIL two_byte_wait%0d valid=%0h ready=%0h exp valid=0 ready=1", i, out_valid, in_ready); end
      if (i < 3) tick;
    end
    send(8'h5A, 8'h77);
    tick;
    in_valid = 1'b0;
    checks++; if (snap !== {1'b1, 2'd1, 3'd1, 3'd3, 8'h5A, 1'b1, 8'h20, 1'b0}) begin errors++; $display("FAIL two_byte got=%h", snap); end
    tick;
    checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL two_byte_drop got=%0h exp=0", out_valid); end
  endtask
  task automatic test_back_to_back;
    for (int i = 1; i <= 3; i++) begin
      send(8'(i), 8'(8'h2F + i));
      checks++; if (in_ready !== 1'b1) begin errors++; $display("FAIL b2b_ready%0d got=%0h exp=1", i, in_ready); end
      tick;
      checks++; if (snap !== {1'b1, 2'd0, 3'd0, 3'(i), 8'h00, 1'b0, 8'(8'h2F + i), 1'b0}) begin errors++; $display("FAIL b2b_issue%0d got=%h", i, snap); end
    end
    in_valid = 1'b0;
    tick;
    checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL b2b_drop got=%0h exp=0", out_valid); end
  endtask
  task automatic test_stall;
    out_ready = 1'b0;
    send(8'h05, 8'h40);
    tick;
    send(8'h06, 8'h41);
    for (int i = 0; i < 4; i++) begin
      checks++; if (in_ready !== 1'b0) begin errors++; $display("FAIL stall_ready%0d got=%0h exp=0", i, in_ready); end
      checks++; if (snap !== {1'b1, 2'd0, 3'd0, 3'd5, 8'h00, 1'b0, 8'h40, 1'b0}) begin errors++; $display("FAIL stall_hold%0d got=%h", i, snap); end
      tick;
    end
    out_ready = 1'b1;
    #1;
    checks++; if (in_ready !== 1'b1) begin errors++; $display("FAIL stall_release_ready got=%0h exp=1", in_ready); end
    tick;
    in_valid = 1'b0;
    checks++; if (snap !== {1'b1, 2'd0, 3'd0, 3'd6, 8'h00, 1'b0, 8'h41, 1'b0}) begin errors++; $display("FAIL stall_next got=%h", snap); end
    tick;
    checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL stall_drop got=%0h exp=0", out_valid); end
  endtask
  task automatic test_flush;
    send(8'h84, 8'h50);
    tick;
    in_valid = 1'b0;
    checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL flush_imm_valid got=%0h exp=0", out_valid); end
    flush = 1'b1;
    #1;
    checks++; if (in_ready !== 1'b0) begin errors++; $display("FAIL flush_ready got=%0h exp=0", in_ready); end
    tick;
    flush = 1'b0;
    send(8'h00, 8'h51);
    tick;
    checks++; if (snap !== {1'b1, 2'd0, 3'd0, 3'd0, 8'h00, 1'b0, 8'h51, 1'b0}) begin errors++; $display("FAIL flush_next got=%h", snap); end
    send(8'h01, 8'h52);
    flush = 1'b1;
    tick;
    flush = 1'b0;
    in_valid = 1'b0;
    checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL flush_hold got=%0h exp=0", out_valid); end
  endtask
  task automatic test_illegal;
    send(8'hFF, 8'h60);
    tick;
    checks++; if (snap !== {1'b1, 2'd3, 3'd7, 3'd7, 8'h00, 1'b0, 8'h60, 1'b1}) begin errors++; $display("FAIL illegal got=%h", snap); end
    send(8'hC0, 8'h61);
    tick;
    checks++; if (snap !== {1'b1, 2'd3, 3'd0, 3'd0, 8'h00, 1'b0, 8'h61, 1'b0}) begin errors++; $display("FAIL c11_short got=%h", snap); end
    send(8'hE5, 8'h62);
    tick;
    checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL c11_long_wait got=%0h exp=0", out_valid); end
    send(8'h11, 8'h63);
    tick;
    in_valid = 1'b0;
    checks++; if (snap !== {1'b1, 2'd3, 3'd4, 3'd5, 8'h11, 1'b1, 8'h62, 1'b0}) begin errors++; $display("FAIL c11_long got=%h", snap); end
    tick;
  endtask
  task automatic test_reset_mid;
    send(8'h4B, 8'h70);
    tick;
    in_valid = 1'b0;
    RST = 1'b1;
    #1;
    checks++; if (out_valid !== 1'b0 || in_ready !== 1'b0) begin errors++; $display("FAIL mid_rst valid=%0h ready=%0h exp 0 0", out_valid, in_ready); end
    RST = 1'b0;
    send(8'h5A, 8'h71);
    tick;
    checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL mid_rst_opc got=%0h exp=0", out_valid); end
    send(8'h00, 8'h72);
    tick;
    in_valid = 1'b0;
    checks++; if (snap !== {1'b1, 2'd1, 3'd3, 3'd2, 8'h00, 1'b1, 8'h71, 1'b0}) begin errors++; $display("FAIL mid_rst_next got=%h", snap); end
    tick;
  endtask
`ifdef AY8_DECODE_ICOUNT_EN
  task automatic test_icount;
    RST = 1'b1;
    tick;
    RST = 1'b0;
    out_ready = 1'b1;
    send(8'h00, 8'h00);
    repeat (65538) tick;
    in_valid = 1'b0;
    checks++; if (out_icount !== 16'd1) begin errors++; $display("FAIL icount_wrap got=%0h exp=1", out_icount); end
  endtask
`endif
  initial begin
    test_reset;
    test_one_byte;
    test_two_byte;
    test_back_to_back;
    test_stall;
    test_flush;
    test_illegal;
    test_reset_mid;
`ifdef AY8_DECODE_ICOUNT_EN
    test_icount;
`endif
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
